// File: rtl/fsab_rr_scheduler.sv
// fsab_rr_scheduler: round-robin owner of the FSAB outbound request bus, holding each grant
// for a whole transaction and metering new grants against the outbound credit pool.
module fsab_rr_scheduler #(
  parameter int NREQ         = 4,
  parameter int LEN_W        = 4,
  parameter int CRED_W       = 4,
  parameter int INIT_CREDITS = 8
) (
  input  logic                      clk,
  input  logic                      Nrst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ-1:0]           req_write,
  input  logic [NREQ*LEN_W-1:0]     req_lens,
  input  logic                      beat_valid,
  input  logic                      fsabo_credit,
  output logic [NREQ-1:0]           grant,
  output logic [NREQ-1:0]           grant_start,
  output logic [$clog2(NREQ)-1:0]   grant_idx,
  output logic                      busy,
  output logic [CRED_W-1:0]         credits
);
  localparam int IW = $clog2(NREQ);
  localparam logic [IW:0] NR = (IW+1)'(NREQ);
  localparam logic [CRED_W-1:0] CMAX = {CRED_W{1'b1}};
  typedef enum logic {IDLE, OWN} state_e;
  state_e            state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d, start_q, start_d;
  logic [IW-1:0]     idx_q, idx_d, last_q, last_d, pick;
  logic              busy_q, busy_d, found, dec;
  logic [CRED_W-1:0] cred_q, cred_d;
  logic [LEN_W-1:0]  beats_q, beats_d, cnt_q, cnt_d, pick_len;
  logic [IW:0]       s;
  // Walk from farthest to nearest candidate so the nearest requester after last wins.
  always_comb begin
    found = 1'b0;
    pick  = last_q;
    s     = '0;
    for (int k = NREQ; k >= 1; k--) begin
      s = {1'b0, last_q} + (IW+1)'(k);
      s = (s >= NR) ? s - NR : s;
      if (req[s[IW-1:0]]) begin
        found = 1'b1;
        pick  = s[IW-1:0];
      end
    end
  end
  assign pick_len = req_lens[pick*LEN_W +: LEN_W];
  assign dec      = (state_q == IDLE) && found && (cred_q != '0);
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    start_d = '0;
    idx_d   = idx_q;
    last_d  = last_q;
    busy_d  = busy_q;
    beats_d = beats_q;
    cnt_d   = cnt_q;
    if (dec) begin
      state_d = OWN;
      grant_d = NREQ'(1) << pick;
      start_d = NREQ'(1) << pick;
      idx_d   = pick;
      last_d  = pick;
      busy_d  = 1'b1;
      beats_d = (req_write[pick] && pick_len != '0) ? pick_len : LEN_W'(1);
      cnt_d   = '0;
    end else if (state_q == OWN && beat_valid) begin
      if (cnt_q + LEN_W'(1) == beats_q) begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + LEN_W'(1);
      end
    end
  end
  // A return on a full counter saturates; a simultaneous grant cancels the return.
  assign cred_d = (fsabo_credit && !dec && cred_q != CMAX) ? cred_q + CRED_W'(1) :
                  (!fsabo_credit && dec)                   ? cred_q - CRED_W'(1) : cred_q;
  always_ff @(posedge clk or negedge Nrst) begin
    if (!Nrst) begin
      state_q <= IDLE;
      grant_q <= '0;
      start_q <= '0;
      idx_q   <= '0;
      last_q  <= IW'(NREQ-1);
      busy_q  <= 1'b0;
      cred_q  <= CRED_W'(INIT_CREDITS);
      beats_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      start_q <= start_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      cred_q  <= cred_d;
      beats_q <= beats_d;
      cnt_q   <= cnt_d;
    end
  end
  assign grant       = grant_q;
  assign grant_start = start_q;
  assign grant_idx   = idx_q;
  assign busy        = busy_q;
  assign credits     = cred_q;
  a_cred_ovf: assert property (@(posedge clk) disable iff (!Nrst)
    !(fsabo_credit && !dec && cred_q == CMAX));
  a_onehot: assert property (@(posedge clk) disable iff (!Nrst) $onehot0(grant_q));
endmodule

// File: tb/tb_fsab_rr_scheduler.sv
// tb_fsab_rr_scheduler: directed stimulus queues expected grants; a negedge monitor
// pops and checks owner, hold duration and idle gap whenever a grant starts or ends.
module tb_fsab_rr_scheduler;
  logic        clk = 1'b0, Nrst = 1'b0;
  logic [3:0]  req = '0, req_write = '0;
  logic [15:0] req_lens = '0;
  logic        beat_valid = 1'b0, fsabo_credit = 1'b0;
  logic [3:0]  grant, grant_start, credits;
  logic [1:0]  grant_idx;
  logic        busy;
  int errors = 0, checks = 0;
  typedef struct {int idx; int dur; int gap;} exp_t;
  exp_t q[$];
  exp_t e;
  int   dur = 0, idle = 100, cur = 0, edur = 0;
  bit   active = 1'b0;

  always #5 clk = ~clk;

  fsab_rr_scheduler dut (
    .clk(clk), .Nrst(Nrst), .req(req), .req_write(req_write), .req_lens(req_lens),
    .beat_valid(beat_valid), .fsabo_credit(fsabo_credit), .grant(grant),
    .grant_start(grant_start), .grant_idx(grant_idx), .busy(busy), .credits(credits)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic void push(input int i, input int d, input int g);
    exp_t x;
    x.idx = i; x.dur = d; x.gap = g;
    q.push_back(x);
  endfunction

  always @(negedge clk) begin
    if (!Nrst) begin
      active = 1'b0;
      idle   = 100;
    end else if (grant_start != '0) begin
      if (active) begin
        chk("duration", dur, edur);
        idle = 0;
      end
      if (q.size() == 0) begin
        chk("unexpected grant", {28'd0, grant_start}, 0);
      end else begin
        e = q.pop_front();
        chk("grant_idx", grant_idx, e.idx);
        chk("grant", grant, 1 << e.idx);
        chk("grant_start", grant_start, 1 << e.idx);
        chk("busy", busy, 1);
        if (e.gap >= 0) chk("gap", idle, e.gap);
        cur = e.idx; edur = e.dur; dur = 1; active = 1'b1;
      end
    end else if (active && grant != '0) begin
      chk("grant hold", grant, 1 << cur);
      dur++;
    end else if (active) begin
      chk("duration", dur, edur);
      chk("busy drop", busy, 0);
      active = 1'b0;
      idle   = 1;
    end else begin
      idle++;
    end
  end

  initial begin
    step(3);
    chk("rst grant", grant, 0);
    chk("rst grant_start", grant_start, 0);
    chk("rst idx", grant_idx, 0);
    chk("rst busy", busy, 0);
    chk("rst credits", credits, 8);
    Nrst = 1'b1;
    step(2);
    beat_valid = 1'b1;
    push(0, 1, -1);
    req = 4'b0001;
    step();
    chk("t1 grant", grant, 1);
    chk("t1 credits", credits, 7);
    req = '0;
    step();
    chk("t1 release", busy, 0);
    step(2);
    push(1, 1, -1); push(2, 1, 1); push(3, 1, 1); push(0, 1, 1);
    push(1, 1, 1);  push(2, 1, 1); push(3, 1, 1);
    req = 4'b1111;
    step(20);
    chk("exhausted credits", credits, 0);
    chk("exhausted grant", grant, 0);
    chk("exhausted busy", busy, 0);
    push(0, 1, -1);
    fsabo_credit = 1'b1;
    step();
    chk("credit return", credits, 1);
    chk("no grant at zero", grant, 0);
    fsabo_credit = 1'b0;
    step();
    chk("grant after credit", grant, 1);
    chk("credits after grant", credits, 0);
    req = '0;
    step(2);
    fsabo_credit = 1'b1;
    step(5);
    fsabo_credit = 1'b0;
    chk("refill", credits, 5);
    beat_valid = 1'b0;
    push(2, 7, -1);
    req = 4'b0100; req_write = 4'b0100; req_lens = 16'h0500;
    step();
    chk("t3 grant", grant, 4);
    chk("t3 credits", credits, 4);
    req = '0; req_write = '0; req_lens = 16'h0100;
    beat_valid = 1'b1;
    step(3);
    beat_valid = 1'b0;
    step(2);
    chk("t3 stall hold", grant, 4);
    beat_valid = 1'b1;
    step();
    chk("t3 beat4 hold", grant, 4);
    step();
    chk("t3 release", busy, 0);
    chk("idx hold", grant_idx, 2);
    push(1, 1, 1);
    req = 4'b0010; req_write = 4'b0010; req_lens = 16'h0000;
    step();
    chk("len0 grant", grant, 2);
    chk("len0 credits", credits, 3);
    req = '0; req_write = '0;
    step();
    chk("len0 release", busy, 0);
    step();
    push(0, 1, -1);
    req = 4'b0001; fsabo_credit = 1'b1;
    step();
    chk("same-cycle credits", credits, 3);
    chk("same-cycle grant", grant, 1);
    req = '0; fsabo_credit = 1'b0;
    step();
    chk("same-cycle after", credits, 3);
    step();
    push(2, 4, -1);
    req = 4'b0100; req_write = 4'b0100; req_lens = 16'h0400;
    step();
    chk("rst-mid grant", grant, 4);
    step(2);
    chk("rst-mid beat2 hold", grant, 4);
    #1 Nrst = 1'b0;
    #1;
    chk("rst-mid grant drop", grant, 0);
    chk("rst-mid busy", busy, 0);
    chk("rst-mid credits", credits, 8);
    req = '0; req_write = '0; req_lens = '0;
    step(2);
    Nrst = 1'b1;
    step();
    push(0, 1, -1); push(2, 1, 1);
    req = 4'b0101;
    step();
    chk("post-rst first", grant, 1);
    step(2);
    chk("post-rst second", grant, 4);
    req = '0;
    step();
    chk("post-rst credits", credits, 6);
    chk("post-rst busy", busy, 0);
    step(3);
    chk("queue empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fsab_rr_scheduler.md
Name: fsab_rr_scheduler

Overview:
- Fair round-robin scheduler that shares the single FSAB outbound request bus among NREQ requesters.
- Grants bus ownership to one requester per transaction and holds the grant for the full transaction (1 beat for reads, len beats for writes).
- Meters grants against the outbound FSAB credit pool.
- Sits between the per-device request buffers and the FSAB output mux, and drives the mux select.

Parameters:
- NREQ, 4, number of requesters (2..16).
- LEN_W, 4, width of a per-requester transaction length field.
- CRED_W, 4, width of the credit counter.
- INIT_CREDITS, 8, credit count loaded at reset; must be < 2^CRED_W.

Ports:
- clk  in  1  system clock.
- Nrst  in  1  asynchronous active-low reset.
- req  in  NREQ  per-requester "transaction pending", level.
- req_write  in  NREQ  per-requester: pending transaction is a write.
- req_lens  in  NREQ*LEN_W  per-requester write length in beats; requester i uses bits [(i+1)*LEN_W-1 : i*LEN_W].
- beat_valid  in  1  FSAB valid beat driven by the currently granted requester.
- fsabo_credit  in  1  one credit returned by the FSAB slave this cycle.
- grant  out  NREQ  one-hot (or zero) ownership vector, registered.
- grant_start  out  NREQ  one-cycle pulse to the newly granted requester, coincident with the first cycle of grant.
- grant_idx  out  clog2(NREQ)  encoded owner, for the output mux; holds the last owner when idle.
- busy  out  1  high while any grant is held.
- credits  out  CRED_W  current credit count.

Behaviour:
- Reset (async, Nrst low):
  - grant=0, grant_start=0, grant_idx=0, busy=0.
  - credits=INIT_CREDITS.
  - Round-robin pointer last=NREQ-1, so requester 0 has first priority.
  - Beat counter=0, FSM=IDLE.
  - Reset asserted mid-transaction drops grant immediately; no credit refund.
- FSM states:
  - IDLE:
    - If any req and credits!=0: select the first i with req[i], searching last+1, last+2, … with wrap modulo NREQ.
    - Next cycle: grant[i]=1, grant_start[i]=1, grant_idx=i, busy=1, last=i.
    - Latch beats = req_write[i] ? max(len_i,1) : 1 (a write len of 0 is treated as 1).
    - Go to OWN.
  - OWN:
    - Each cycle with beat_valid, increment the beat counter.
    - On the beat where the count reaches the latched beats: grant and busy deassert next cycle; go to IDLE.
    - beat_valid=0 stalls the transaction indefinitely.
- Arbitration latency: 1 cycle from req to grant. There is exactly one IDLE bubble cycle between the release of one grant and the next grant.
- req_write and req_lens are sampled only in the cycle the grant decision is made. Later changes are ignored until the next grant.
- A requester dropping req while granted does not end the grant; only beat counting ends it.
- beat_valid while busy=0 is ignored.
- Credits:
  - Decrement by 1 in the cycle the grant decision is made (the cycle before grant_start).
  - Increment by 1 on fsabo_credit.
  - Both in the same cycle: unchanged.
  - credits=0 blocks new grants but never aborts a transaction in progress.
  - A credit returned in the same cycle the count is 0 does not enable a grant that cycle; the grant happens the following cycle.
  - An increment past 2^CRED_W-1 is a protocol error; simulation asserts and the counter saturates.
- Fairness: with all NREQ requesting continuously, each requester gets exactly one grant per NREQ grants.
- grant is always one-hot or zero. grant_start is high only in the first OWN cycle.

Test Plan:
- Reset, then req=4'b0001 with a read and beat_valid in the cycle after grant_start -> grant=0001 for 1 cycle after grant_start; credits goes 8 -> 7; busy then drops; a new grant cannot come earlier than 1 idle cycle later.
- req=4'b1111 held, all reads, beat_valid every owned cycle -> grant order 0,1,2,3,0,1…; each grant lasts 1 cycle; grants are 2 cycles apart.
- Requester 2 write with len=5 and beat_valid gapped (3 beats, 2 idle cycles, 2 beats) -> grant=0100 for 7 cycles; releases after the 5th beat. Write with len=0 -> releases after 1 beat.
- INIT_CREDITS=2, no fsabo_credit, req=4'b0011 -> 2 grants, then credits=0 and no further grant. Pulse fsabo_credit -> credits=1, and a grant is decided the next cycle.
- Grant decision and fsabo_credit in the same cycle at credits=3 -> credits stays 3.
- Nrst pulsed low during a 4-beat write at beat 2 -> grant=0 immediately; credits=INIT_CREDITS; after release, requester 0 has priority.
